// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse meter: FSM encoding and default sizing,
// also used by the pulser bench.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meter_state_t;

  localparam int CNT_W_DEFAULT   = 24;
  localparam int TIMEOUT_DEFAULT = 16777215;

endpackage

// File: rtl/pulse_meter_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level with rise/fall strobes.
// Strobes stay quiet until the synchronizer history is valid after reset.
module pulse_meter_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic [SYNC_STAGES:0]   primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
      primed <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_d    <= sync_q[SYNC_STAGES-1];
      primed <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A level already high when reset releases must not look like a fresh edge.
  assign rise = primed[SYNC_STAGES] &  s & ~s_d;
  assign fall = primed[SYNC_STAGES] & ~s &  s_d;

endmodule

// File: rtl/pulse_meter.sv
// Measures high time and period of an incoming pulse train in CLK cycles and
// presents each result on a valid/ready register with overrun and stall flags.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PULSE_IN,
  output logic [CNT_W-1:0] HIGH_CNT,
  output logic [CNT_W-1:0] PERIOD_CNT,
  output logic             VALID,
  input  logic             READY,
  output logic             OVERRUN,
  output logic             STALL,
  input  logic             CLR
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              rise;
  logic              fall;
  logic              edge_seen;
  logic              timeout_hit;
  logic              emit;
  logic              accept;
  logic              drop;
  meter_state_t      state;
  meter_state_t      state_nxt;
  logic [CNT_W-1:0]  hcnt;
  logic [CNT_W-1:0]  pcnt;
  logic [IDLE_W-1:0] idle_cnt;

  pulse_meter_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (CLK),
    .rst_n (RST),
    .din   (PULSE_IN),
    .rise  (rise),
    .fall  (fall)
  );

  assign edge_seen   = rise | fall;
  assign timeout_hit = !edge_seen && (idle_cnt == IDLE_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    case (state)
      IDLE: if (rise) state_nxt = HIGH;
      HIGH: if (fall) state_nxt = LOW;
      LOW: begin
        if (rise) begin
          state_nxt = HIGH;
          emit      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) begin
      state_nxt = IDLE;
      emit      = 1'b0;
    end
  end

  // The edge cycle belongs to the phase it starts, so the fall cycle adds to
  // the period but not to the high count.
  always_ff @(posedge CLK) begin
    case (state)
      IDLE: begin
        if (rise) begin
          hcnt <= CNT_W'(1);
          pcnt <= CNT_W'(1);
        end
      end
      HIGH: begin
        pcnt <= sat_inc(pcnt);
        if (!fall) hcnt <= sat_inc(hcnt);
      end
      LOW: begin
        if (rise) begin
          hcnt <= CNT_W'(1);
          pcnt <= CNT_W'(1);
        end else begin
          pcnt <= sat_inc(pcnt);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idle_cnt <= '0;
    end else if (edge_seen) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      STALL <= 1'b0;
    end else if (timeout_hit) begin
      STALL <= 1'b1;
    end else if (rise) begin
      STALL <= 1'b0;
    end
  end

  // Output register: a result arriving while the slot is full and not being
  // drained is discarded in favour of the one already presented.
  assign accept = VALID && READY;
  assign drop   = emit && VALID && !READY;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      HIGH_CNT   <= '0;
      PERIOD_CNT <= '0;
      VALID      <= 1'b0;
    end else if (emit && !drop) begin
      HIGH_CNT   <= hcnt;
      PERIOD_CNT <= pcnt;
      VALID      <= 1'b1;
    end else if (accept) begin
      VALID      <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVERRUN <= 1'b0;
    end else if (drop) begin
      OVERRUN <= 1'b1;
    end else if (CLR) begin
      OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: a 24-bit instance for measurement, handshake,
// timeout and reset scenarios, and a 4-bit instance for counter saturation.
module tb_pulse_meter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CLR = 1'b0;

  logic        pin = 1'b0;
  logic        ready = 1'b1;
  logic [23:0] high_cnt;
  logic [23:0] period_cnt;
  logic        valid;
  logic        overrun;
  logic        stall;

  logic        sat_pin = 1'b0;
  logic        sat_ready = 1'b1;
  logic [3:0]  sat_high;
  logic [3:0]  sat_period;
  logic        sat_valid;
  logic        sat_overrun;
  logic        sat_stall;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_meter #(.CNT_W(24), .SYNC_STAGES(2), .TIMEOUT(100)) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .PULSE_IN   (pin),
    .HIGH_CNT   (high_cnt),
    .PERIOD_CNT (period_cnt),
    .VALID      (valid),
    .READY      (ready),
    .OVERRUN    (overrun),
    .STALL      (stall),
    .CLR        (CLR)
  );

  pulse_meter #(.CNT_W(4), .SYNC_STAGES(2), .TIMEOUT(100)) u_sat (
    .CLK        (CLK),
    .RST        (RST),
    .PULSE_IN   (sat_pin),
    .HIGH_CNT   (sat_high),
    .PERIOD_CNT (sat_period),
    .VALID      (sat_valid),
    .READY      (sat_ready),
    .OVERRUN    (sat_overrun),
    .STALL      (sat_stall),
    .CLR        (CLR)
  );

  initial forever #5 CLK = ~CLK;

  // Drive both pins just after a rising edge, then return at the falling edge.
  task automatic tick(input logic p, input logic ps);
    @(posedge CLK);
    #1;
    pin     = p;
    sat_pin = ps;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if ({valid, overrun, stall, high_cnt, period_cnt} !== {3'b000, 24'd0, 24'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b o=%0b s=%0b h=%0d p=%0d, expected all 0",
               valid, overrun, stall, high_cnt, period_cnt);
    end
    n_checks++;
    if ({sat_valid, sat_overrun, sat_stall, sat_high, sat_period} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_sat_outputs: got v=%0b o=%0b s=%0b h=%0d p=%0d, expected all 0",
               sat_valid, sat_overrun, sat_stall, sat_high, sat_period);
    end
    RST = 1'b1;
    repeat (4) tick(1'b0, 1'b0);
    n_checks++;
    if ({valid, stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: got v=%0b s=%0b, expected 0 0", valid, stall);
    end
  endtask

  task automatic test_periodic();
    int nv;
    nv = 0;
    ready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 32; c++) begin
        tick(c < 10, 1'b0);
        if (valid) begin
          nv++;
          n_checks++;
          if ({high_cnt, period_cnt} !== {24'd10, 24'd32}) begin
            n_fail++;
            $display("FAIL periodic_value: got h=%0d p=%0d, expected h=10 p=32",
                     high_cnt, period_cnt);
          end
        end
      end
    end
    n_checks++;
    if (nv != 5) begin
      n_fail++;
      $display("FAIL periodic_valid_count: got %0d, expected 5", nv);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL periodic_overrun: got %0b, expected 0", overrun);
    end
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 20; c++) begin
        tick(c < 6, 1'b0);
        if (p == 0 && c == 3) begin
          n_checks++;
          if ({valid, overrun, high_cnt, period_cnt} !== {2'b10, 24'd10, 24'd32}) begin
            n_fail++;
            $display("FAIL ovr_first_load: got v=%0b o=%0b h=%0d p=%0d, expected v=1 o=0 h=10 p=32",
                     valid, overrun, high_cnt, period_cnt);
          end
        end
        if (p == 1 && c == 3) begin
          n_checks++;
          if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set: got %0b, expected 1", overrun);
          end
        end
      end
    end
    n_checks++;
    if ({valid, overrun, high_cnt, period_cnt} !== {2'b11, 24'd10, 24'd32}) begin
      n_fail++;
      $display("FAIL ovr_hold: got v=%0b o=%0b h=%0d p=%0d, expected v=1 o=1 h=10 p=32",
               valid, overrun, high_cnt, period_cnt);
    end
    CLR = 1'b1;
    tick(1'b0, 1'b0);
    CLR = 1'b0;
    n_checks++;
    if ({valid, overrun, high_cnt, period_cnt} !== {2'b10, 24'd10, 24'd32}) begin
      n_fail++;
      $display("FAIL ovr_clr: got v=%0b o=%0b h=%0d p=%0d, expected v=1 o=0 h=10 p=32",
               valid, overrun, high_cnt, period_cnt);
    end
    ready = 1'b1;
    tick(1'b0, 1'b0);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_drain: got valid=%0b, expected 0", valid);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_drain_stays_low: got valid=%0b, expected 0", valid);
    end
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(c < 8, 1'b0);
      if (c == 3) begin
        n_checks++;
        if ({valid, high_cnt, period_cnt} !== {1'b1, 24'd6, 24'd23}) begin
          n_fail++;
          $display("FAIL b2b_first: got v=%0b h=%0d p=%0d, expected v=1 h=6 p=23",
                   valid, high_cnt, period_cnt);
        end
      end
    end
    for (int c = 0; c < 14; c++) begin
      tick(c < 5, 1'b0);
      if (c == 2) begin
        n_checks++;
        if ({valid, high_cnt, period_cnt} !== {1'b1, 24'd6, 24'd23}) begin
          n_fail++;
          $display("FAIL b2b_before: got v=%0b h=%0d p=%0d, expected v=1 h=6 p=23",
                   valid, high_cnt, period_cnt);
        end
        ready = 1'b1;
      end
      if (c == 3) begin
        n_checks++;
        if ({valid, overrun, high_cnt, period_cnt} !== {2'b10, 24'd8, 24'd20}) begin
          n_fail++;
          $display("FAIL b2b_reload: got v=%0b o=%0b h=%0d p=%0d, expected v=1 o=0 h=8 p=20",
                   valid, overrun, high_cnt, period_cnt);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_drain: got valid=%0b, expected 0", valid);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int nv;
    nv = 0;
    ready = 1'b1;
    for (int c = 0; c < 160; c++) begin
      tick(c < 10, 1'b0);
      if (valid) nv++;
      if (c == 3) begin
        n_checks++;
        if ({valid, high_cnt, period_cnt} !== {1'b1, 24'd5, 24'd14}) begin
          n_fail++;
          $display("FAIL to_pre_result: got v=%0b h=%0d p=%0d, expected v=1 h=5 p=14",
                   valid, high_cnt, period_cnt);
        end
      end
      if (c == 112) begin
        n_checks++;
        if (stall !== 1'b0) begin
          n_fail++;
          $display("FAIL to_stall_early: got %0b, expected 0", stall);
        end
      end
      if (c == 113) begin
        n_checks++;
        if (stall !== 1'b1) begin
          n_fail++;
          $display("FAIL to_stall_set: got %0b, expected 1", stall);
        end
      end
    end
    for (int c = 0; c < 32; c++) begin
      tick(c < 10, 1'b0);
      if (valid) nv++;
      if (c == 2) begin
        n_checks++;
        if (stall !== 1'b1) begin
          n_fail++;
          $display("FAIL to_stall_held: got %0b, expected 1", stall);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (stall !== 1'b0) begin
          n_fail++;
          $display("FAIL to_stall_clear: got %0b, expected 0", stall);
        end
      end
    end
    n_checks++;
    if (nv != 1) begin
      n_fail++;
      $display("FAIL to_no_emit: got %0d valid cycles, expected 1", nv);
    end
    for (int c = 0; c < 32; c++) begin
      tick(c < 10, 1'b0);
      if (c == 3) begin
        n_checks++;
        if ({valid, high_cnt, period_cnt} !== {1'b1, 24'd10, 24'd32}) begin
          n_fail++;
          $display("FAIL to_first_result: got v=%0b h=%0d p=%0d, expected v=1 h=10 p=32",
                   valid, high_cnt, period_cnt);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int nv;
    nv = 0;
    sat_ready = 1'b1;
    n_checks++;
    if (sat_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_idle_stall: got %0b, expected 1", sat_stall);
    end
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 25; c++) begin
        tick(c < 20, c < 20);
        if (sat_valid) begin
          nv++;
          n_checks++;
          if ({sat_high, sat_period} !== {4'd15, 4'd15}) begin
            n_fail++;
            $display("FAIL sat_value: got h=%0d p=%0d, expected h=15 p=15",
                     sat_high, sat_period);
          end
        end
      end
    end
    n_checks++;
    if (nv != 2) begin
      n_fail++;
      $display("FAIL sat_valid_count: got %0d, expected 2", nv);
    end
    n_checks++;
    if ({sat_stall, sat_overrun} !== 2'b00) begin
      n_fail++;
      $display("FAIL sat_flags: got s=%0b o=%0b, expected 0 0", sat_stall, sat_overrun);
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    ready = 1'b0;
    for (int c = 0; c < 32; c++) begin
      tick(c < 10, 1'b0);
      if (c == 3) begin
        n_checks++;
        if ({valid, high_cnt, period_cnt} !== {1'b1, 24'd20, 24'd25}) begin
          n_fail++;
          $display("FAIL rm_setup: got v=%0b h=%0d p=%0d, expected v=1 h=20 p=25",
                   valid, high_cnt, period_cnt);
        end
      end
    end
    for (int c = 0; c < 5; c++) tick(1'b1, 1'b0);
    n_checks++;
    if ({valid, overrun} !== 2'b11) begin
      n_fail++;
      $display("FAIL rm_before: got v=%0b o=%0b, expected 1 1", valid, overrun);
    end
    #2;
    RST = 1'b0;
    #1;
    n_checks++;
    if ({valid, overrun, stall, high_cnt, period_cnt} !== {3'b000, 24'd0, 24'd0}) begin
      n_fail++;
      $display("FAIL rm_async_clear: got v=%0b o=%0b s=%0b h=%0d p=%0d, expected all 0",
               valid, overrun, stall, high_cnt, period_cnt);
    end
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    RST = 1'b1;
    ready = 1'b1;
    nv = 0;
    for (int c = 7; c < 32; c++) begin
      tick(c < 10, 1'b0);
      if (valid) nv++;
    end
    for (int c = 0; c < 32; c++) begin
      tick(c < 10, 1'b0);
      if (valid) nv++;
    end
    n_checks++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL rm_no_early_result: got %0d valid cycles, expected 0", nv);
    end
    for (int c = 0; c < 32; c++) begin
      tick(c < 10, 1'b0);
      if (c == 3) begin
        n_checks++;
        if ({valid, high_cnt, period_cnt} !== {1'b1, 24'd10, 24'd32}) begin
          n_fail++;
          $display("FAIL rm_first_result: got v=%0b h=%0d p=%0d, expected v=1 h=10 p=32",
                   valid, high_cnt, period_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
